// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial add/subtract unit.
// The FSM state enum, mode encodings and a constant clog2 for sizing counters.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// One K-bit digit of the add/subtract chain: ripple of full adders or full subtractors.
// c_msb_in exposes the carry/borrow entering bit K-1 so the top can form signed overflow.
module addsub_digit
  import addsub_pkg::*;
#(
  parameter int K = 2
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         cin,
  input  logic         mode,
  output logic [K-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);

  logic c;

  // In subtract mode c is a borrow: generated when a<b, propagated when a==b.
  always_comb begin
    c        = cin;
    s        = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (i == K - 1) c_msb_in = c;
      s[i] = a[i] ^ b[i] ^ c;
      if (mode == MODE_ADD)
        c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      else
        c = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c);
    end
    cout = c;
  end

endmodule

// File: rtl/addsub_digit_serial.sv
// Multi-cycle N-bit add/subtract processing K bits per clock, LSB digit first,
// with a start/done handshake and registered result plus carry/overflow/zero flags.
module addsub_digit_serial
  import addsub_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] R,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int NDIG = N / K;
  localparam int CW   = (NDIG > 1) ? clog2(NDIG) : 1;

  generate
    if ((K < 1) || (K > N) || ((N % K) != 0)) begin : g_bad_cfg
      $error("addsub_digit_serial: K must divide N with 1 <= K <= N");
    end
  endgenerate

  state_t         state;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [N-1:0]   res_sh;
  logic [N-1:0]   res_next;
  logic           mode_q;
  logic           carry_q;
  logic [CW-1:0]  cnt;
  logic [K-1:0]   dig_s;
  logic           dig_cout;
  logic           dig_msb_in;
  logic           last_digit;

  addsub_digit #(.K(K)) u_digit (
    .a        (a_sh[K-1:0]),
    .b        (b_sh[K-1:0]),
    .cin      (carry_q),
    .mode     (mode_q),
    .s        (dig_s),
    .cout     (dig_cout),
    .c_msb_in (dig_msb_in)
  );

  // Digit results enter from the MSB side so after N/K digits the word is aligned.
  generate
    if (K == N) begin : g_single_digit
      assign res_next = dig_s;
    end else begin : g_multi_digit
      assign res_next = {dig_s, res_sh[N-1:K]};
    end
  endgenerate

  assign last_digit = (cnt == CW'(NDIG - 1));

  // R and the flags are only written on the last RUN edge, so they hold through DONE/IDLE
  // and across a back-to-back operation until it completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      mode_q  <= MODE_ADD;
      carry_q <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      R       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh    <= A;
            b_sh    <= B;
            mode_q  <= mode;
            carry_q <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> K;
          b_sh    <= b_sh >> K;
          res_sh  <= res_next;
          carry_q <= dig_cout;
          cnt     <= cnt + 1'b1;
          if (last_digit) begin
            R     <= res_next;
            cout  <= dig_cout;
            ovf   <= dig_cout ^ dig_msb_in;
            zero  <= (res_next == '0);
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_digit_serial.sv
// Scoreboard bench: directed handshake/corner steps on K=2, random sweeps on K=1, K=2 and K=8.
module tb_addsub_digit_serial;

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       v;
    logic       z;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start_req;
  logic       tb_mode;
  logic [7:0] tb_a;
  logic [7:0] tb_b;
  logic [3:0] sel;

  logic       start1, start2, start8;
  logic       busy1, busy2, busy8;
  logic       done1, done2, done8;
  logic [7:0] r1, r2, r8;
  logic       cout1, cout2, cout8;
  logic       ovf1, ovf2, ovf8;
  logic       zero1, zero2, zero8;

  logic       o_busy, o_done, o_cout, o_ovf, o_zero;
  logic [7:0] o_r;

  int   checks;
  int   errors;
  int   cycle;
  int   start_cycle;
  exp_t sb[$];
  exp_t prev;

  assign start1 = start_req && (sel == 4'd1);
  assign start2 = start_req && (sel == 4'd2);
  assign start8 = start_req && (sel == 4'd8);

  addsub_digit_serial #(.N(8), .K(1)) u_k1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(tb_mode), .A(tb_a), .B(tb_b),
    .busy(busy1), .done(done1), .R(r1), .cout(cout1), .ovf(ovf1), .zero(zero1));

  addsub_digit_serial #(.N(8), .K(2)) u_k2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(tb_mode), .A(tb_a), .B(tb_b),
    .busy(busy2), .done(done2), .R(r2), .cout(cout2), .ovf(ovf2), .zero(zero2));

  addsub_digit_serial #(.N(8), .K(8)) u_k8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(tb_mode), .A(tb_a), .B(tb_b),
    .busy(busy8), .done(done8), .R(r8), .cout(cout8), .ovf(ovf8), .zero(zero8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    o_busy = busy2; o_done = done2; o_r = r2; o_cout = cout2; o_ovf = ovf2; o_zero = zero2;
    case (sel)
      4'd1: begin o_busy = busy1; o_done = done1; o_r = r1; o_cout = cout1; o_ovf = ovf1; o_zero = zero1; end
      4'd8: begin o_busy = busy8; o_done = done8; o_r = r8; o_cout = cout8; o_ovf = ovf8; o_zero = zero8; end
      default: ;
    endcase
  end

  function automatic exp_t model(input logic m, input logic [7:0] a, input logic [7:0] b);
    exp_t       e;
    logic [8:0] t;
    if (m == 1'b0) begin
      t   = {1'b0, a} + {1'b0, b};
      e.v = (a[7] == b[7]) && (t[7] != a[7]);
    end else begin
      t   = {1'b0, a} - {1'b0, b};
      e.v = (a[7] != b[7]) && (t[7] != a[7]);
    end
    e.r = t[7:0];
    e.c = t[8];
    e.z = (t[7:0] == 8'd0);
    return e;
  endfunction

  function automatic int latency(input logic [3:0] s);
    return 8 / int'(s) + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drives one accepted start (caller guarantees IDLE or DONE) and records the expected result.
  task automatic applyStimulus(input logic [3:0] s, input logic m, input logic [7:0] a, input logic [7:0] b);
    sel         = s;
    tb_mode     = m;
    tb_a        = a;
    tb_b        = b;
    start_req   = 1'b1;
    start_cycle = cycle;
    sb.push_back(model(m, a, b));
    tick();
    start_req = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    int   lat;
    lat = latency(sel);
    while (!o_done && (cycle < start_cycle + lat + 3)) tick();
    check({tag, "_done"}, 16'(o_done), 16'd1);
    check({tag, "_lat"}, 16'(cycle - start_cycle), 16'(lat));
    e = sb.pop_front();
    check({tag, "_R"}, 16'(o_r), 16'(e.r));
    check({tag, "_cout"}, 16'(o_cout), 16'(e.c));
    check({tag, "_ovf"}, 16'(o_ovf), 16'(e.v));
    check({tag, "_zero"}, 16'(o_zero), 16'(e.z));
    prev = e;
  endtask

  initial begin
    int   done_seen;
    logic m;
    logic [7:0] a, b;
    logic [7:0] corners [4];
    corners[0] = 8'h00; corners[1] = 8'hFF; corners[2] = 8'h7F; corners[3] = 8'h80;
    checks = 0; errors = 0; cycle = 0; start_cycle = 0;
    prev = '0;
    rst_n = 1'b0; start_req = 1'b0; tb_mode = 1'b0; tb_a = 8'h00; tb_b = 8'h00; sel = 4'd2;
    repeat (3) tick();
    check("rst_busy", 16'(o_busy), 16'd0);
    check("rst_done", 16'(o_done), 16'd0);
    check("rst_R", 16'(o_r), 16'd0);
    check("rst_flags", 16'({o_cout, o_ovf, o_zero}), 16'd0);
    rst_n = 1'b1;
    tick();

    // Basic add: busy through cycles 1-4, done in cycle 5.
    applyStimulus(4'd2, 1'b0, 8'd100, 8'd27);
    for (int i = 1; i <= 4; i++) begin
      check("t1_busy", 16'(o_busy), 16'd1);
      check("t1_early_done", 16'(o_done), 16'd0);
      if (i < 4) tick();
    end
    checkOutput("t1");
    check("t1_R127", 16'(o_r), 16'd127);
    tick();
    check("t1_done_pulse", 16'(o_done), 16'd0);

    applyStimulus(4'd2, 1'b1, 8'd5, 8'd7);     checkOutput("sub_neg");
    check("sub_neg_FE", 16'(o_r), 16'h00FE);
    tick();
    applyStimulus(4'd2, 1'b1, 8'h33, 8'h33);   checkOutput("sub_zero");
    applyStimulus(4'd2, 1'b0, 8'h7F, 8'h01);   checkOutput("add_ovf");
    check("add_ovf_flag", 16'(o_ovf), 16'd1);
    applyStimulus(4'd2, 1'b1, 8'h80, 8'h01);   checkOutput("sub_ovf");
    applyStimulus(4'd2, 1'b0, 8'hFF, 8'h01);   checkOutput("add_wrap");
    check("add_wrap_zero", 16'(o_zero), 16'd1);
    tick();

    // Starts while busy are ignored.
    applyStimulus(4'd2, 1'b0, 8'd10, 8'd20);
    tick();
    tb_a = 8'hAA; tb_b = 8'h55; tb_mode = 1'b1; start_req = 1'b1;
    tick();
    tick();
    start_req = 1'b0;
    checkOutput("ignore");
    check("ignore_R30", 16'(o_r), 16'd30);

    // Back-to-back start in the DONE cycle; R held while the new op runs.
    applyStimulus(4'd2, 1'b1, 8'h10, 8'h20);
    check("b2b_busy", 16'(o_busy), 16'd1);
    check("b2b_R_held", 16'(o_r), 16'(prev.r));
    checkOutput("b2b");

    // Reset in cycle 2 of RUN aborts with no done pulse.
    tick();
    applyStimulus(4'd2, 1'b0, 8'h12, 8'h34);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    check("abort_busy", 16'(o_busy), 16'd0);
    check("abort_done", 16'(o_done), 16'd0);
    check("abort_R", 16'(o_r), 16'd0);
    check("abort_flags", 16'({o_cout, o_ovf, o_zero}), 16'd0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_done) done_seen++;
    end
    check("abort_no_done", 16'(done_seen), 16'd0);
    applyStimulus(4'd2, 1'b1, 8'h12, 8'h34);   checkOutput("after_abort");

    // Random sweeps with corner operands mixed in.
    for (int cfg = 0; cfg < 3; cfg++) begin
      for (int n = 0; n < ((cfg == 0) ? 150 : 250); n++) begin
        m = 1'($urandom_range(0, 1));
        a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 8'($urandom);
        b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 8'($urandom);
        applyStimulus((cfg == 0) ? 4'd1 : ((cfg == 1) ? 4'd8 : 4'd2), m, a, b);
        checkOutput((cfg == 0) ? "rnd_k1" : ((cfg == 1) ? "rnd_k8" : "rnd_k2"));
        if ($urandom_range(0, 2) == 0) tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
